// File: rtl/mock_alu_pkg.sv
// Shared definitions for the mock-ALU shifter path.
// Covers opcodes, shifter direction codes, widths and the opcode-to-direction decode.
package mock_alu_pkg;

  localparam int DATA_W  = 64;
  localparam int SHIFT_W = 6;

  typedef enum logic [1:0] {
    OP_SRL = 2'd0,
    OP_SRA = 2'd1,
    OP_SLL = 2'd2,
    OP_ILL = 2'd3
  } op_e;

  localparam logic [SHIFT_W-1:0] DIR_SLL = 6'hB;
  localparam logic [SHIFT_W-1:0] DIR_SRL = 6'hC;
  localparam logic [SHIFT_W-1:0] DIR_SRA = 6'hD;

  function automatic logic [SHIFT_W-1:0] op_dir(input op_e op);
    case (op)
      OP_SRL:  return DIR_SRL;
      OP_SRA:  return DIR_SRA;
      OP_SLL:  return DIR_SLL;
      default: return '0;
    endcase
  endfunction

endpackage

// File: rtl/shift_issue_fifo.sv
// Generic DEPTH x WIDTH synchronous FIFO with occupancy count.
// The head entry is read combinationally and reads as zero while the FIFO is empty.
module shift_issue_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  assign head = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/shift_issue_queue.sv
// Issue stage ahead of the 64-bit barrel shifter.
// Decodes and saturates requests on accept, buffers them, and issues one per cycle.
module shift_issue_queue
  import mock_alu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     io_in_valid,
  output logic                     io_in_ready,
  input  logic [1:0]               io_in_bits_op,
  input  logic [DATA_W-1:0]        io_in_bits_data,
  input  logic [6:0]               io_in_bits_amount,
  input  logic [TAG_W-1:0]         io_in_bits_tag,
  output logic                     io_out_valid,
  input  logic                     io_out_ready,
  output logic [DATA_W-1:0]        io_out_data,
  output logic [SHIFT_W-1:0]       io_out_shiftAmount,
  output logic [SHIFT_W-1:0]       io_out_dir,
  output logic [TAG_W-1:0]         io_out_tag,
  output logic                     io_illegal,
  output logic [$clog2(DEPTH):0]   io_count
);

  localparam int ENTRY_W = DATA_W + SHIFT_W + SHIFT_W + TAG_W;

  op_e                op;
  logic [DATA_W-1:0]  dec_data;
  logic [SHIFT_W-1:0] dec_amount;
  logic [SHIFT_W-1:0] dec_dir;
  logic               accept;
  logic               push;
  logic               pop;
  logic               full;
  logic               empty;
  logic [ENTRY_W-1:0] head;

  assign op = op_e'(io_in_bits_op);

  // Amounts of 64 or more: logical shifts clear the word, SRA keeps the sign fill via 63.
  always_comb begin
    dec_data   = io_in_bits_data;
    dec_amount = io_in_bits_amount[SHIFT_W-1:0];
    dec_dir    = op_dir(op);
    if (io_in_bits_amount[6]) begin
      if (op == OP_SRA) begin
        dec_amount = 6'd63;
      end else begin
        dec_data   = '0;
        dec_amount = '0;
      end
    end
  end

  assign accept = io_in_valid && io_in_ready;
  assign push   = accept && (op != OP_ILL);
  assign pop    = io_out_valid && io_out_ready;

  shift_issue_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .push_data ({dec_data, dec_amount, dec_dir, io_in_bits_tag}),
    .pop       (pop),
    .head      (head),
    .count     (io_count),
    .full      (full),
    .empty     (empty)
  );

  assign io_in_ready  = !full;
  assign io_out_valid = !empty;
  assign {io_out_data, io_out_shiftAmount, io_out_dir, io_out_tag} = head;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) io_illegal <= 1'b0;
    else       io_illegal <= accept && (op == OP_ILL);
  end

endmodule

// File: tb/tb_shift_issue_queue.sv
// Directed test of shift_issue_queue: decode, saturation, illegal drop, backpressure and reset.
module tb_shift_issue_queue;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  in_op = '0;
  logic [63:0] in_data = '0;
  logic [6:0]  in_amount = '0;
  logic [3:0]  in_tag = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] out_data;
  logic [5:0]  out_amount;
  logic [5:0]  out_dir;
  logic [3:0]  out_tag;
  logic        illegal;
  logic [2:0]  count;

  int checks = 0;
  int fails  = 0;

  shift_issue_queue #(.DEPTH(4), .TAG_W(4)) dut (
    .clock              (clock),
    .reset              (reset),
    .io_in_valid        (in_valid),
    .io_in_ready        (in_ready),
    .io_in_bits_op      (in_op),
    .io_in_bits_data    (in_data),
    .io_in_bits_amount  (in_amount),
    .io_in_bits_tag     (in_tag),
    .io_out_valid       (out_valid),
    .io_out_ready       (out_ready),
    .io_out_data        (out_data),
    .io_out_shiftAmount (out_amount),
    .io_out_dir         (out_dir),
    .io_out_tag         (out_tag),
    .io_illegal         (illegal),
    .io_count           (count)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Presents one request for one clock edge, then withdraws it.
  task automatic push_cycle(input logic [1:0] op, input logic [63:0] data,
                            input logic [6:0] amt, input logic [3:0] tag);
    in_valid = 1'b1; in_op = op; in_data = data; in_amount = amt; in_tag = tag;
    $display("req op=%0d data=%h amt=%0d tag=%0h ready=%0b out_ready=%0b",
             op, data, amt, tag, in_ready, out_ready);
    step();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; out_ready = 1'b0;
    #12;
    checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_ready got=%b exp=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    checks++; if (count !== 3'd0) begin fails++; $display("FAIL reset_count got=%0d exp=0", count); end
    checks++; if (illegal !== 1'b0) begin fails++; $display("FAIL reset_illegal got=%b exp=0", illegal); end
    checks++; if ({out_data, out_amount, out_dir, out_tag} !== 80'd0) begin
      fails++; $display("FAIL reset_fields got=%h exp=0", {out_data, out_amount, out_dir, out_tag}); end
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_srl();
    out_ready = 1'b1;
    push_cycle(2'd0, 64'hF000_0000_0000_0000, 7'd4, 4'd3);
    checks++; if (out_valid !== 1'b1) begin fails++; $display("FAIL srl_valid got=%b exp=1", out_valid); end
    checks++; if (out_dir !== 6'hC) begin fails++; $display("FAIL srl_dir got=%h exp=c", out_dir); end
    checks++; if (out_amount !== 6'd4) begin fails++; $display("FAIL srl_amount got=%0d exp=4", out_amount); end
    checks++; if (out_data !== 64'hF000_0000_0000_0000) begin fails++; $display("FAIL srl_data got=%h exp=f000000000000000", out_data); end
    checks++; if (out_tag !== 4'd3) begin fails++; $display("FAIL srl_tag got=%0h exp=3", out_tag); end
    step();
    checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL srl_drained got=%b exp=0", out_valid); end
    checks++; if (out_data !== 64'd0) begin fails++; $display("FAIL empty_data got=%h exp=0", out_data); end
  endtask

  task automatic test_sll_sat();
    out_ready = 1'b1;
    push_cycle(2'd2, 64'h1234_5678_9ABC_DEF0, 7'd64, 4'd5);
    checks++; if (out_data !== 64'd0) begin fails++; $display("FAIL sll_data got=%h exp=0", out_data); end
    checks++; if (out_amount !== 6'd0) begin fails++; $display("FAIL sll_amount got=%0d exp=0", out_amount); end
    checks++; if (out_dir !== 6'hB) begin fails++; $display("FAIL sll_dir got=%h exp=b", out_dir); end
    step();
  endtask

  task automatic test_sra_sat();
    out_ready = 1'b1;
    push_cycle(2'd1, 64'h8000_0000_0000_0000, 7'd100, 4'd6);
    checks++; if (out_data !== 64'h8000_0000_0000_0000) begin fails++; $display("FAIL sra_data got=%h exp=8000000000000000", out_data); end
    checks++; if (out_amount !== 6'd63) begin fails++; $display("FAIL sra_amount got=%0d exp=63", out_amount); end
    checks++; if (out_dir !== 6'hD) begin fails++; $display("FAIL sra_dir got=%h exp=d", out_dir); end
    checks++; if (out_tag !== 4'd6) begin fails++; $display("FAIL sra_tag got=%0h exp=6", out_tag); end
    step();
  endtask

  task automatic test_illegal();
    out_ready = 1'b1;
    checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL ill_ready got=%b exp=1", in_ready); end
    push_cycle(2'd3, 64'hDEAD_BEEF, 7'd3, 4'd7);
    checks++; if (illegal !== 1'b1) begin fails++; $display("FAIL ill_pulse got=%b exp=1", illegal); end
    checks++; if (count !== 3'd0) begin fails++; $display("FAIL ill_count got=%0d exp=0", count); end
    checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL ill_valid got=%b exp=0", out_valid); end
    step();
    checks++; if (illegal !== 1'b0) begin fails++; $display("FAIL ill_pulse_end got=%b exp=0", illegal); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      push_cycle(2'd0, 64'(i), 7'd1, 4'(i));
      checks++; if (count !== 3'(i + 1)) begin fails++; $display("FAIL bp_count%0d got=%0d exp=%0d", i, count, i + 1); end
    end
    checks++; if (in_ready !== 1'b0) begin fails++; $display("FAIL bp_full_ready got=%b exp=0", in_ready); end
    push_cycle(2'd0, 64'd9, 7'd1, 4'd9);
    checks++; if (count !== 3'd4) begin fails++; $display("FAIL bp_fifth_count got=%0d exp=4", count); end
    checks++; if (out_tag !== 4'd0) begin fails++; $display("FAIL bp_head_tag got=%0h exp=0", out_tag); end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++; if (out_tag !== 4'(i) || out_valid !== 1'b1) begin
        fails++; $display("FAIL bp_drain%0d got tag=%0h valid=%b exp tag=%0h valid=1", i, out_tag, out_valid, i); end
      step();
    end
    checks++; if (count !== 3'd0) begin fails++; $display("FAIL bp_drained got=%0d exp=0", count); end
  endtask

  task automatic test_push_pop();
    out_ready = 1'b0;
    push_cycle(2'd2, 64'd4, 7'd2, 4'd4);
    push_cycle(2'd2, 64'd5, 7'd2, 4'd5);
    checks++; if (count !== 3'd2) begin fails++; $display("FAIL pp_pre_count got=%0d exp=2", count); end
    out_ready = 1'b1;
    push_cycle(2'd2, 64'd6, 7'd2, 4'd6);
    checks++; if (count !== 3'd2) begin fails++; $display("FAIL pp_count got=%0d exp=2", count); end
    checks++; if (out_tag !== 4'd5) begin fails++; $display("FAIL pp_head got=%0h exp=5", out_tag); end
    step();
    checks++; if (out_tag !== 4'd6) begin fails++; $display("FAIL pp_next got=%0h exp=6", out_tag); end
    step();
    checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL pp_empty got=%b exp=0", out_valid); end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      push_cycle(2'd1, 64'hA0 + 64'(i), 7'd8, 4'(8 + i));
      checks++; if (out_tag !== 4'(8 + i) || count !== 3'd1) begin
        fails++; $display("FAIL b2b%0d got tag=%0h count=%0d exp tag=%0h count=1", i, out_tag, count, 8 + i); end
    end
    step();
    checks++; if (count !== 3'd0) begin fails++; $display("FAIL b2b_end got=%0d exp=0", count); end
  endtask

  task automatic test_reset_midstream();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) push_cycle(2'd0, 64'hFF, 7'd1, 4'(i + 1));
    checks++; if (count !== 3'd3) begin fails++; $display("FAIL mid_pre_count got=%0d exp=3", count); end
    #2 reset = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0 || count !== 3'd0 || in_ready !== 1'b1) begin
      fails++; $display("FAIL mid_reset got valid=%b count=%0d ready=%b exp 0/0/1", out_valid, count, in_ready); end
    checks++; if (out_data !== 64'd0 || out_tag !== 4'd0) begin
      fails++; $display("FAIL mid_fields got data=%h tag=%0h exp 0", out_data, out_tag); end
    #2 reset = 1'b0;
    push_cycle(2'd0, 64'h55, 7'd5, 4'hA);
    checks++; if (count !== 3'd1 || out_tag !== 4'hA || out_valid !== 1'b1) begin
      fails++; $display("FAIL mid_after got count=%0d tag=%0h valid=%b exp 1/a/1", count, out_tag, out_valid); end
    checks++; if (out_amount !== 6'd5 || out_data !== 64'h55) begin
      fails++; $display("FAIL mid_after_fields got amt=%0d data=%h exp 5/55", out_amount, out_data); end
  endtask

  initial begin
    test_reset();
    test_srl();
    test_sll_sat();
    test_sra_sat();
    test_illegal();
    test_backpressure();
    test_push_pop();
    test_back_to_back();
    test_reset_midstream();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/shift_issue_queue.md
# shift_issue_queue

Upstream issue stage for the mock-ALU 64-bit barrel shifter. Accepts tagged shift requests over a valid/ready handshake and decodes the opcode into the shifter's direction code. It saturates 7-bit shift amounts into the shifter's 6-bit range, buffers requests in a small FIFO, and presents one decoded operation per cycle to the shifter stage over valid/ready.

## Interface
Parameters:
- DEPTH, 4, FIFO entries; power of two, at least 2
- TAG_W, 4, request tag width; carried through unchanged

Ports:
- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high
- io_in_valid  in  1  request present
- io_in_ready  out  1  queue can accept a request
- io_in_bits_op  in  2  0=SRL, 1=SRA, 2=SLL, 3=illegal
- io_in_bits_data  in  64  operand
- io_in_bits_amount  in  7  shift amount, 0..127
- io_in_bits_tag  in  TAG_W  request tag
- io_out_valid  out  1  decoded op available
- io_out_ready  in  1  shifter stage consumes op
- io_out_data  out  64  operand to shifter
- io_out_shiftAmount  out  6  amount to shifter
- io_out_dir  out  6  direction code to shifter
- io_out_tag  out  TAG_W  tag of the presented op
- io_illegal  out  1  one-cycle pulse when an illegal op is dropped
- io_count  out  $clog2(DEPTH)+1  current occupancy

## Operation
- Accept on io_in_valid && io_in_ready. Pop on io_out_valid && io_out_ready.
- Decode happens at accept time and the FIFO stores the decoded fields: data, amount, dir, tag.
- Direction codes:
  - SRL → 6'hC
  - SRA → 6'hD
  - SLL → 6'hB
- Saturation, applied when amount ≥ 64:
  - SRL/SLL: data forced to 0, amount forced to 0.
  - SRA: data unchanged, amount forced to 63, which yields the sign fill.
- Amounts below 64 pass through as amount[5:0] with data unchanged.
- Illegal op (3):
  - The handshake still completes; io_in_ready is honoured.
  - Nothing is written to the FIFO.
  - io_illegal pulses high in the following cycle.
- io_in_ready = (count != DEPTH). There is no same-cycle pass-through when full, even if a pop occurs that cycle.
- io_out_valid = (count != 0). The io_out_* fields show the head entry and are held stable while io_out_valid && !io_out_ready.
- Simultaneous push and pop when neither full nor empty: count unchanged, both pointers advance.
- Pointers wrap modulo DEPTH.
- When the FIFO is empty, io_out_data, io_out_shiftAmount, io_out_dir and io_out_tag are 0.

## Timing
- Latency: a request accepted in cycle N is visible on io_out_* with io_out_valid=1 in cycle N+1 when the queue was empty.
- Throughput: one accept and one issue per cycle.
- io_in_ready and io_out_valid are derived from registered count only. There is no combinational path from io_out_ready to io_in_ready.
- io_illegal is registered: high for exactly one cycle, in cycle N+1 after an illegal accept in cycle N.
- Reset (asynchronous assert, any cycle):
  - count=0, pointers=0.
  - io_out_valid=0, io_in_ready=1, io_illegal=0, io_count=0.
  - All io_out_* data fields are 0.
  - In-flight entries are discarded.
- The first accept can occur in the cycle after reset deassertion.

## Structure
- Shared package mock_alu_pkg holds:
  - op enum: OP_SRL, OP_SRA, OP_SLL, OP_ILL
  - direction constants: DIR_SLL=6'hB, DIR_SRL=6'hC, DIR_SRA=6'hD
  - SHIFT_W=6 and DATA_W=64
- One sub-module, shift_issue_fifo: a generic DEPTH × width synchronous FIFO with count output.
- Decode and saturation logic live in the top module, ahead of the FIFO write port.

## Test plan
- After reset: io_in_ready=1, io_out_valid=0, io_count=0.
- SRL of data 0xF000_0000_0000_0000, amount 4, tag 3, io_out_ready=1 → next cycle: io_out_valid=1, dir=0xC, shiftAmount=4, data unchanged, tag=3.
- SLL with amount 64 → data=0, shiftAmount=0, dir=0xB.
- SRA of data 0x8000_0000_0000_0000 with amount 100 → data unchanged, shiftAmount=63, dir=0xD.
- Illegal op with tag 7 → io_illegal pulses for exactly one cycle, io_count stays 0, io_out_valid stays 0.
- Backpressure:
  - With io_out_ready=0, push DEPTH=4 requests → io_in_ready=0 and io_count=4.
  - A fifth io_in_valid is not accepted.
  - Holding io_out_ready=1 while pushing → outputs drain in order with tags 0,1,2,3.
  - A push and pop in the same cycle at count=2 keeps count=2.
- Assert reset mid-stream with count=3 → outputs clear immediately (asynchronous). The next accepted request appears alone in the cycle after accept.
